// File: rtl/pipe_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_regfile_sb
//  Description : Multi-port register file with a pending-write scoreboard.
//                Combinational reads with same-cycle write-through bypass,
//                one saturating in-flight write counter per register, and a
//                read-after-write stall request for the operand-fetch stage.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i       clock, all state updates on the rising edge
//    rst_ni      asynchronous active-low reset (data and counters cleared)
//    rd_addr_i   read addresses, port k at [k*ADDR_W +: ADDR_W]
//    rd_req_i    port k operand is used this cycle
//    rd_data_o   read data, port k at [k*DATA_W +: DATA_W]
//    rd_busy_o   port k register has an unresolved pending write
//    wr_en_i     writeback enable
//    wr_addr_i   writeback destination
//    wr_data_i   writeback data
//    iss_en_i    instruction writing iss_addr_i leaves decode this cycle
//    iss_addr_i  destination of the issuing instruction
//    flush_i     discard all pending-write tracking
//    iss_full_o  pending counter of iss_addr_i is saturated
//    stall_o     hazard stall request to the front end
//  Build option
//    ZERO_REG_EN : when defined, register 0 is hard-wired to zero, writes to
//                  it are dropped and issues to it are never tracked.
// ============================================================================
module pipe_regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int PEND_W = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    input  logic [NUM_RD-1:0]        rd_req_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    input  logic                     flush_i,
    output logic                     iss_full_o,
    output logic                     stall_o
);

    localparam int                NUM_REGS = 2**ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [PEND_W-1:0] pend_q [NUM_REGS];
    logic [PEND_W-1:0] pend_d [NUM_REGS];

    logic                w_wr_en;
    logic                w_iss_en;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;

    // Effective write / issue enables: register 0 swallows both when hard-wired.
    assign w_wr_en  = wr_en_i  && !(ZERO_REG && (wr_addr_i  == '0));
    assign w_iss_en = iss_en_i && !(ZERO_REG && (iss_addr_i == '0));

    assign iss_full_o = (pend_q[iss_addr_i] == PEND_MAX) &&
                        !(ZERO_REG && (iss_addr_i == '0));

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic              w_hit;

            assign w_addr = rd_addr_i[k*ADDR_W +: ADDR_W];
            assign w_hit  = w_wr_en && (wr_addr_i == w_addr);

            always_comb begin
                if (ZERO_REG && (w_addr == '0)) begin
                    rd_data_o[k*DATA_W +: DATA_W] = '0;
                end else if (w_hit) begin
                    rd_data_o[k*DATA_W +: DATA_W] = wr_data_i;
                end else begin
                    rd_data_o[k*DATA_W +: DATA_W] = regs_q[w_addr];
                end
            end

            // The last outstanding write landing this cycle is covered by the
            // bypass, so the operand is not busy.
            assign rd_busy_o[k] = (pend_q[w_addr] != '0) &&
                                  !(w_hit && (pend_q[w_addr] == PEND_ONE));
        end
    endgenerate

    assign stall_o = (|(rd_req_i & rd_busy_o)) | (iss_en_i & iss_full_o);

    // ------------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_inc[r] = w_iss_en && (iss_addr_i == ADDR_W'(r)) && !iss_full_o;
            // Writebacks to an untracked register update data only.
            w_dec[r] = w_wr_en && (wr_addr_i == ADDR_W'(r)) && (pend_q[r] != '0);
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_d[r] = pend_q[r];
            if (flush_i) begin
                // Flush wipes tracking first; a same-cycle issue is kept.
                pend_d[r] = w_inc[r] ? PEND_ONE : '0;
            end else begin
                pend_d[r] = pend_q[r] + (w_inc[r] ? PEND_ONE : '0)
                                      - (w_dec[r] ? PEND_ONE : '0);
            end
        end
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                regs_q[wr_addr_i] <= wr_data_i;
            end
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= pend_d[r];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_regfile_sb
//  Description : Directed testbench for pipe_regfile_sb. Stimulus is applied
//                just after a rising edge and its hand-computed expected
//                outputs are queued; a monitor compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int PEND_W = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_req;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;
    logic                     iss_full;
    logic                     stall;

    pipe_regfile_sb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .PEND_W (PEND_W)
    ) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_req_i   (rd_req),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .flush_i    (flush),
        .iss_full_o (iss_full),
        .stall_o    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        stl;
        logic        full;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s got=%h want=%h", nm, fld, got, want);
        end
    endtask

    // Monitor: outputs are stable by the falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp(e.nm, "rd_data0", rd_data[31:0],  e.d0);
            cmp(e.nm, "rd_data1", rd_data[63:32], e.d1);
            cmp(e.nm, "rd_busy",  32'(rd_busy),   32'(e.busy));
            cmp(e.nm, "stall",    32'(stall),     32'(e.stl));
            cmp(e.nm, "iss_full", 32'(iss_full),  32'(e.full));
        end
    end

    // One cycle of stimulus plus its expected response.
    task automatic step(input string nm, input logic rstv,
                        input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] req,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ia, input logic fl,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input logic [1:0] eb, input logic es, input logic ef);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n    = rstv;
        rd_addr  = {a1, a0};
        rd_req   = req;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        flush    = fl;
        e.nm = nm; e.d0 = e0; e.d1 = e1; e.busy = eb; e.stl = es; e.full = ef;
        sb_q.push_back(e);
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;

    initial begin
        rst_n = 1'b0; rd_addr = '0; rd_req = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; iss_en = 1'b0; iss_addr = '0; flush = 1'b0;

        //    name          rst a0  a1  req  we wa  wd            ie ia  fl  e0            e1  busy  stl full
        // Reset state
        step("rst_hold",    0,  3,  7,  2'b00, 0, 0,  0,            0, 0,  0, 0,            0, 2'b00, 0, 0);
        step("rst_rel",     1,  3,  7,  2'b00, 0, 0,  0,            0, 0,  0, 0,            0, 2'b00, 0, 0);
        // Write-through bypass, then registered value
        step("wr_bypass",   1,  3,  5,  2'b00, 1, 5,  DB,           0, 0,  0, 0,            DB, 2'b00, 0, 0);
        step("wr_stored",   1,  3,  5,  2'b00, 0, 0,  0,            0, 0,  0, 0,            DB, 2'b00, 0, 0);
        // RAW hazard on r9
        step("iss_r9",      1,  9,  5,  2'b01, 0, 0,  0,            1, 9,  0, 0,            DB, 2'b00, 0, 0);
        step("raw_r9_a",    1,  9,  5,  2'b01, 0, 0,  0,            0, 0,  0, 0,            DB, 2'b01, 1, 0);
        step("raw_r9_b",    1,  9,  5,  2'b01, 0, 0,  0,            0, 0,  0, 0,            DB, 2'b01, 1, 0);
        step("wb_r9",       1,  9,  5,  2'b01, 1, 9,  32'h12,       0, 0,  0, 32'h12,       DB, 2'b00, 0, 0);
        step("r9_clear",    1,  9,  5,  2'b01, 0, 0,  0,            0, 0,  0, 32'h12,       DB, 2'b00, 0, 0);
        // Counter saturation on r4
        step("iss4_1",      1,  4,  5,  2'b00, 0, 0,  0,            1, 4,  0, 0,            DB, 2'b00, 0, 0);
        step("iss4_2",      1,  4,  5,  2'b00, 0, 0,  0,            1, 4,  0, 0,            DB, 2'b01, 0, 0);
        step("iss4_3",      1,  4,  5,  2'b00, 0, 0,  0,            1, 4,  0, 0,            DB, 2'b01, 0, 0);
        step("iss4_full",   1,  4,  5,  2'b00, 0, 0,  0,            1, 4,  0, 0,            DB, 2'b01, 1, 1);
        step("full_hold",   1,  4,  5,  2'b00, 0, 0,  0,            0, 4,  0, 0,            DB, 2'b01, 0, 1);
        step("wb4_1",       1,  4,  5,  2'b00, 1, 4,  32'h41,       0, 4,  0, 32'h41,       DB, 2'b01, 0, 1);
        step("wb4_iss",     1,  4,  5,  2'b00, 1, 4,  32'h42,       1, 4,  0, 32'h42,       DB, 2'b01, 0, 0);
        step("p4_two",      1,  4,  5,  2'b01, 0, 0,  0,            0, 4,  0, 32'h42,       DB, 2'b01, 1, 0);
        step("wb4_2",       1,  4,  5,  2'b01, 1, 4,  32'h43,       0, 0,  0, 32'h43,       DB, 2'b01, 1, 0);
        step("wb4_last",    1,  4,  5,  2'b01, 1, 4,  32'h44,       0, 0,  0, 32'h44,       DB, 2'b00, 0, 0);
        step("wb4_under",   1,  4,  5,  2'b01, 1, 4,  32'h45,       0, 0,  0, 32'h45,       DB, 2'b00, 0, 0);
        step("iss4_post",   1,  4,  5,  2'b01, 0, 0,  0,            1, 4,  0, 32'h45,       DB, 2'b00, 0, 0);
        step("p4_one",      1,  4,  5,  2'b01, 0, 0,  0,            0, 4,  0, 32'h45,       DB, 2'b01, 1, 0);
        step("wb4_fin",     1,  4,  5,  2'b01, 1, 4,  32'h46,       0, 0,  0, 32'h46,       DB, 2'b00, 0, 0);
        // Flush with a same-cycle issue
        step("iss_r2",      1,  2,  6,  2'b00, 0, 0,  0,            1, 2,  0, 0,            0, 2'b00, 0, 0);
        step("iss_r6",      1,  2,  6,  2'b00, 0, 0,  0,            1, 6,  0, 0,            0, 2'b01, 0, 0);
        step("flush_iss6",  1,  2,  6,  2'b00, 0, 0,  0,            1, 6,  1, 0,            0, 2'b11, 0, 0);
        step("post_flush",  1,  2,  6,  2'b11, 0, 0,  0,            0, 0,  0, 0,            0, 2'b10, 1, 0);
        step("wb_r6",       1,  2,  6,  2'b11, 1, 6,  32'h66,       0, 0,  0, 0,            32'h66, 2'b00, 0, 0);
        // Register 0 behaviour
`ifdef ZERO_REG_EN
        step("r0_wr_iss",   1,  0,  5,  2'b01, 1, 0,  32'h55,       1, 0,  0, 0,            DB, 2'b00, 0, 0);
        step("r0_read",     1,  0,  5,  2'b01, 0, 0,  0,            0, 0,  0, 0,            DB, 2'b00, 0, 0);
`else
        step("r0_wr_iss",   1,  0,  5,  2'b01, 1, 0,  32'h55,       1, 0,  0, 32'h55,       DB, 2'b00, 0, 0);
        step("r0_read",     1,  0,  5,  2'b01, 0, 0,  0,            0, 0,  0, 32'h55,       DB, 2'b01, 1, 0);
`endif
        // Asynchronous reset mid-operation: r9 pending, then reset between edges
        step("iss_r9_b",    1,  9,  5,  2'b00, 0, 0,  0,            1, 9,  0, 32'h12,       DB, 2'b00, 0, 0);
        step("async_rst",   0,  9,  5,  2'b11, 0, 0,  0,            0, 0,  0, 0,            0, 2'b00, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got=%0d want=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_regfile_sb.md
Name: pipe_regfile_sb

Overview:
Parametrised register file with a pending-write scoreboard, intended as the next-generation register file for the pipelined RISC CPU.
- Adds NUM_RD read ports, same-cycle write-through bypass and per-register in-flight write counters.
- Produces a stall request for the decode/operand-fetch stage, so read-after-write hazards are detected instead of silently reading stale data.
- Sits between the decoder (issue side) and the writeback mux (write side).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
NUM_RD, 2, number of independent read ports
PEND_W, 2, width of each per-register pending-write counter (max 2**PEND_W-1 in flight)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; clears all registers and counters
rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_req  in  NUM_RD  port k operand is actually used this cycle
rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  port k register has an unresolved pending write
wr_en  in  1  writeback enable
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data
iss_en  in  1  an instruction writing iss_addr is leaving decode this cycle
iss_addr  in  ADDR_W  destination of the issuing instruction
flush  in  1  discard all pending-write tracking (branch/jump squash)
iss_full  out  1  pend[iss_addr] at maximum; issue must not proceed
stall  out  1  hazard stall request to the front end

Behaviour:
- Reset, asserted asynchronously: all NUM_REGS data registers = 0, all pend counters = 0. Combinational outputs follow from this state; rd_data = 0, rd_busy = 0, iss_full = 0, stall = 0 when rd_req = 0 and iss_en = 0.
- Reads are combinational, zero latency. rd_data[k] = wr_data if wr_en && wr_addr == rd_addr[k] (write-through bypass); otherwise reg[rd_addr[k]]. All ports are independent; any ports may read the same address.
- Write: on a rising edge with wr_en, reg[wr_addr] <= wr_data.
- Scoreboard next state for every register r:
  - inc = iss_en && iss_addr == r && !iss_full.
  - dec = wr_en && wr_addr == r && pend[r] != 0.
  - flush: pend[r] <= inc ? 1 : 0. Flush clears first, then the same-cycle issue is counted. A writeback in the flush cycle still updates data.
  - No flush: pend[r] <= pend[r] + inc - dec. If inc and dec are both set, pend[r] is unchanged.
- Underflow: a writeback to a register with pend = 0 writes data; the counter stays 0.
- Overflow: when pend[iss_addr] == 2**PEND_W-1, iss_full = 1 and the issue is not counted.
- rd_busy[k] = pend[a] != 0 && !(wr_en && wr_addr == a && pend[a] == 1), where a = rd_addr[k]. The last outstanding write arriving this cycle is satisfied by the bypass.
- stall = |(rd_req & rd_busy) | (iss_en & iss_full). It is combinational and does not gate any internal state; the front end must deassert iss_en while stalling.
- Reset asserted mid-operation discards all data and pending state immediately, with no clock edge required.

Optional Feature:
ZERO_REG_EN
- Defined: register 0 is hard-wired.
  - Reads of address 0 return 0, with no bypass.
  - Writes to address 0 are dropped.
  - Issues to address 0 are never counted; pend[0] is constant 0.
  - rd_busy for address 0 is 0, and iss_full is 0 when iss_addr = 0.
- Undefined: register 0 behaves as an ordinary register.

Test Plan:
1. Reset low, then high; read ports 0/1 at addr 3/7 -> rd_data = 0/0, rd_busy = 00, stall = 0.
2. Write 0xDEADBEEF to r5 and, in the same cycle, read r5 on port 1 -> rd_data1 = 0xDEADBEEF in that cycle; next cycle, with wr_en = 0, still 0xDEADBEEF.
3. Issue r9, then read r9 with rd_req = 01 for 2 cycles -> rd_busy0 = 1, stall = 1. Then write r9 = 0x12 -> in that cycle rd_busy0 = 0, stall = 0, rd_data0 = 0x12.
4. Issue r4 three times (PEND_W = 2) -> pend = 3. A fourth issue gives iss_full = 1, stall = 1, pend stays 3. Three writebacks -> pend = 0. A writeback while issuing r4 in the same cycle leaves pend unchanged.
5. Issue r2 and r6, then flush together with an issue of r6 -> next cycle pend[2] = 0, pend[6] = 1. A read of r2 is not busy; a read of r6 is busy.
6. With ZERO_REG_EN defined: write 0x55 to r0, issue r0, read r0 -> rd_data = 0, rd_busy = 0, stall = 0. Without the macro -> rd_data = 0x55 and r0 is busy after the issue.
